// File: rtl/eth_dma_mem_pkg.sv
// Shared types for the DMA-facing Wishbone memory: FSM states and termination kinds.
package eth_dma_mem_pkg;
  localparam int WORD_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {RESP_ACK, RESP_ERR} resp_e;
endpackage

// File: rtl/eth_dma_wb_mem_if.sv
// Wishbone classic bus between the MAC DMA master and the buffer memory slave.
interface eth_dma_wb_mem_if;
  import eth_dma_mem_pkg::*;

  logic [31:0]       wb_adr_i;
  logic [WORD_W-1:0] wb_dat_i;
  logic [SEL_W-1:0]  wb_sel_i;
  logic              wb_we_i;
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic [WORD_W-1:0] wb_dat_o;
  logic              wb_ack_o;
  logic              wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/eth_dma_mem_ram.sv
// Single-port word RAM: byte-enabled write, synchronous 1-cycle read; contents survive reset.
module eth_dma_mem_ram
  import eth_dma_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdat,
  input  logic                  re,
  output logic [WORD_W-1:0]     rdat
);
  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (sel[b]) mem[addr][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
    if (re) rdat <= mem[addr];
  end
endmodule

// File: rtl/eth_dma_wb_mem.sv
// Wishbone classic slave memory for the MAC DMA port with programmable wait states and error injection.
// Termination is a registered 1-cycle pulse W+1 edges after accept; next accept no earlier than two edges later.
module eth_dma_wb_mem
  import eth_dma_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          CNT_W      = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  eth_dma_wb_mem_if.slave  wb,
  input  logic [3:0]       wait_cfg_i,
  input  logic             err_inject_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);
  state_e                state_q, state_d;
  resp_e                 resp_q;
  logic [3:0]            wcnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  we_q;
  logic [SEL_W-1:0]      sel_q;
  logic [WORD_W-1:0]     dat_q;
  logic                  inj_used_q, inj_flag_q, ack_q, err_q;
  logic [31:0]           off;
  logic                  req, in_win, bad_adr, accept, resp_edge, ram_we, ram_re;
  logic [WORD_W-1:0]     ram_q;

  assign req     = wb.wb_cyc_i & wb.wb_stb_i;
  // Subtraction wraps addresses below the base to huge offsets, so one compare covers both ends.
  assign off     = wb.wb_adr_i - BASE_ADDR;
  assign in_win  = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign bad_adr = !in_win || (wb.wb_adr_i[1:0] != 2'b00);
  // Hold off while a termination is still visible so the master can drop stb first.
  assign accept  = (state_q == IDLE) && req && !ack_q && !err_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    resp_edge = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = (wait_cfg_i == 4'd0) ? RESP : WAIT;
      WAIT: begin
        if (!req)                  state_d = IDLE;
        else if (wcnt_q == 4'd0)   state_d = RESP;
      end
      RESP: begin
        state_d   = IDLE;
        resp_edge = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      resp_q     <= RESP_ACK;
      wcnt_q     <= 4'd0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
      inj_used_q <= 1'b0;
      inj_flag_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_cnt_o   <= '0;
      wr_cnt_o   <= '0;
      err_cnt_o  <= '0;
    end else begin
      ack_q <= resp_edge && (resp_q == RESP_ACK);
      err_q <= resp_edge && (resp_q == RESP_ERR);

      if (accept) begin
        idx_q      <= off[DEPTH_LOG2+1:2];
        we_q       <= wb.wb_we_i;
        sel_q      <= wb.wb_sel_i;
        dat_q      <= wb.wb_dat_i;
        wcnt_q     <= wait_cfg_i - 4'd1;
        inj_used_q <= inj_flag_q || err_inject_i;
        resp_q     <= (bad_adr || inj_flag_q || err_inject_i) ? RESP_ERR : RESP_ACK;
      end else if (state_q == WAIT && wcnt_q != 4'd0) begin
        wcnt_q <= wcnt_q - 4'd1;
      end

      // Single-shot: only a completed error transfer consumes the armed flag; aborts leave it set.
      if (resp_edge && inj_used_q) inj_flag_q <= 1'b0;
      else if (err_inject_i)       inj_flag_q <= 1'b1;

      if (resp_edge) begin
        if (resp_q == RESP_ERR) begin
          if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
        end else if (we_q) begin
          if (wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + CNT_W'(1);
        end else begin
          if (rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + CNT_W'(1);
        end
      end
    end
  end

  assign ram_we = resp_edge && (resp_q == RESP_ACK) && we_q && !wb_rst_i;
  assign ram_re = resp_edge && (resp_q == RESP_ACK) && !we_q;

  eth_dma_mem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk  (wb_clk_i),
    .we   (ram_we),
    .sel  (sel_q),
    .addr (idx_q),
    .wdat (dat_q),
    .re   (ram_re),
    .rdat (ram_q)
  );

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_dat_o = (ack_q && !we_q) ? ram_q : '0;
endmodule
